// File: rtl/frame_buffer_mem_if.sv
// Command, write-stream and read-stream signals of the single-frame pixel store.
// The controller side uses master; the buffer itself uses slave.
interface frame_buffer_mem_if #(
  parameter int PIX_W = 8
);
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic             cmd_ready;
  logic             abort;
  logic             wr_valid;
  logic [PIX_W-1:0] wr_data;
  logic             wr_ready;
  logic             rd_valid;
  logic [PIX_W-1:0] rd_data;
  logic             rd_ready;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, abort, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, abort, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done
  );
endinterface

// File: rtl/frame_buffer_mem.sv
// Single-frame pixel store with WRITE / READ / CLEAR commands and streaming
// valid/ready pixel ports at one pixel per cycle.
module frame_buffer_mem #(
  parameter int DATA_W = 8,
  parameter int CH     = 1,
  parameter int IMG_H  = 64,
  parameter int IMG_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  frame_buffer_mem_if.slave bus
);
  localparam int PIX_W  = CH * DATA_W;
  localparam int FRAME  = IMG_H * IMG_W;
  localparam int ADDR_W = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, CLEAR} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0]  mem [FRAME];
  logic [PIX_W-1:0]  mem_q;
  logic [PIX_W-1:0]  rd_data;
  logic              rd_valid, rd_last;
  logic              pend, pend_last;
  logic              all_issued;
  logic              done, done_next;
  logic              cmd_fire, wr_fire, rd_fire, advance, issue, finish;

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    finish     = 1'b0;
    cmd_fire   = bus.cmd_valid && (state == IDLE);
    wr_fire    = bus.wr_valid && (state == WRITE);
    rd_fire    = rd_valid && bus.rd_ready && (state == READ);
    advance    = (state == READ) && (!rd_valid || bus.rd_ready);
    issue      = advance && !all_issued;
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          case (bus.cmd_op)
            2'b00:   state_next = READ;
            2'b01:   state_next = WRITE;
            2'b10:   state_next = CLEAR;
            default: done_next  = 1'b1;
          endcase
        end
      end
      WRITE:   finish = wr_fire && (addr == LAST_ADDR);
      READ:    finish = rd_fire && rd_last;
      CLEAR:   finish = (addr == LAST_ADDR);
      default: finish = 1'b0;
    endcase
    // abort wins over a coinciding completion, so it never produces done
    if ((state != IDLE) && (bus.abort || finish)) begin
      state_next = IDLE;
      done_next  = finish && !bus.abort;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // The read path is a two-stage pipe (memory register, then output register)
  // that shifts as one unit whenever the output slot is free or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      pend       <= 1'b0;
      pend_last  <= 1'b0;
      all_issued <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= done_next;
      if ((state == IDLE) || (state_next == IDLE)) begin
        addr       <= '0;
        rd_valid   <= 1'b0;
        rd_last    <= 1'b0;
        pend       <= 1'b0;
        pend_last  <= 1'b0;
        all_issued <= 1'b0;
      end else begin
        if (wr_fire || (state == CLEAR)) addr <= addr + ADDR_W'(1);
        if (advance) begin
          rd_valid  <= pend;
          rd_last   <= pend_last;
          if (pend) rd_data <= mem_q;
          pend      <= issue;
          pend_last <= issue && (addr == LAST_ADDR);
          if (issue) begin
            if (addr == LAST_ADDR) all_issued <= 1'b1;
            else                   addr       <= addr + ADDR_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire)               mem[addr] <= bus.wr_data;
    else if (state == CLEAR)   mem[addr] <= '0;
    if (issue)                 mem_q     <= mem[addr];
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.wr_ready  = (state == WRITE);
  assign bus.busy      = (state != IDLE);
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_data   = rd_data;
  assign bus.done      = done;
endmodule

// File: tb/tb_frame_buffer_mem.sv
// Self-checking bench for frame_buffer_mem on a 4x4 RGB frame; a plain array
// holds the expected frame contents and is updated from accepted pixels.
module tb_frame_buffer_mem;
  localparam int PIX_W = 24;
  localparam int FRAME = 16;

  typedef struct {
    logic [1:0] op;
    bit         rand_data;
    int         gap_every;
    int         abort_at;
    bit         stall;
    bit         hold_nop;
    bit         exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [PIX_W-1:0] ref_mem [FRAME];
  vec_t vecs [11];

  frame_buffer_mem_if #(.PIX_W(PIX_W)) bus ();

  frame_buffer_mem #(
    .DATA_W(8),
    .CH(3),
    .IMG_H(4),
    .IMG_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op);
    int w = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    while (!bus.cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check_output("cmd_accept_timeout", 32'(w), 32'd0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_clear();
    int c = 0;
    send_cmd(2'b10);
    bus.wr_valid = 1'b1;
    bus.rd_ready = 1'b1;
    check_output("clear_busy", bus.busy, 1);
    check_output("clear_cmd_ready", bus.cmd_ready, 0);
    while (!bus.done && c < 64) begin
      @(negedge clk);
      c++;
    end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    check_output("clear_latency", 32'(c), 32'd16);
    check_output("clear_busy_after", bus.busy, 0);
    for (int i = 0; i < FRAME; i++) ref_mem[i] = '0;
  endtask

  task automatic do_write(input vec_t v);
    int p = 0, c = 0, early = 0, exp_p;
    bit fire, aborted = 0;
    logic [PIX_W-1:0] d;
    exp_p = (v.abort_at >= 0) ? v.abort_at + 1 : FRAME;
    send_cmd(2'b01);
    while (p < FRAME && !aborted && c < 400) begin
      if (bus.done) early++;
      d = v.rand_data ? PIX_W'($urandom) : PIX_W'(p);
      if (v.gap_every > 0)      bus.wr_valid = (c % v.gap_every) != (v.gap_every - 1);
      else if (v.gap_every < 0) bus.wr_valid = 1'($urandom_range(0, 1));
      else                      bus.wr_valid = 1'b1;
      bus.wr_data = d;
      bus.abort   = bus.wr_valid && (p == v.abort_at);
      fire = bus.wr_valid && bus.wr_ready;
      @(negedge clk);
      c++;
      if (fire) begin
        ref_mem[p] = d;
        p++;
        aborted = bus.abort;
      end
    end
    bus.wr_valid = 1'b0;
    bus.abort    = 1'b0;
    check_output("wr_count", 32'(p), 32'(exp_p));
    check_output("wr_early_done", 32'(early), 32'd0);
    check_output("wr_done", bus.done, 32'(v.exp_done));
    check_output("wr_busy_after", bus.busy, 0);
  endtask

  task automatic do_read(input vec_t v);
    int p = 0, c = 0, first_c = -1, last_c = -1, early = 0, early_ready = 0;
    bit was_stalled = 0;
    logic [PIX_W-1:0] held = '0;
    send_cmd(2'b00);
    if (v.hold_nop) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b11;
    end
    while (p < FRAME && c < 400) begin
      if (bus.done) early++;
      if (bus.cmd_ready) early_ready++;
      if (was_stalled) begin
        check_output("rd_hold_valid", bus.rd_valid, 1);
        check_output("rd_hold_data", 32'(bus.rd_data), 32'(held));
      end
      bus.rd_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      was_stalled = 0;
      if (bus.rd_valid) begin
        if (first_c < 0) first_c = c;
        if (bus.rd_ready) begin
          check_output("rd_data", 32'(bus.rd_data), 32'(ref_mem[p]));
          last_c = c;
          p++;
        end else begin
          was_stalled = 1;
          held = bus.rd_data;
        end
      end
      @(negedge clk);
      c++;
    end
    bus.rd_ready = 1'b0;
    check_output("rd_count", 32'(p), 32'(FRAME));
    check_output("rd_first_latency", 32'(first_c), 32'd2);
    if (!v.stall) check_output("rd_throughput", 32'(last_c), 32'd17);
    check_output("rd_early_done", 32'(early), 32'd0);
    check_output("rd_cmd_ready_busy", 32'(early_ready), 32'd0);
    check_output("rd_done", bus.done, 32'(v.exp_done));
    check_output("rd_valid_after", bus.rd_valid, 0);
    check_output("rd_cmd_ready_after", bus.cmd_ready, 1);
    if (v.hold_nop) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      check_output("held_nop_done", bus.done, 1);
    end
  endtask

  task automatic do_nop();
    send_cmd(2'b11);
    check_output("nop_done", bus.done, 1);
    check_output("nop_busy", bus.busy, 0);
  endtask

  task automatic apply_stimulus(input vec_t v);
    case (v.op)
      2'b00:   do_read(v);
      2'b01:   do_write(v);
      2'b10:   do_clear();
      default: do_nop();
    endcase
    @(negedge clk);
    check_output("done_width", bus.done, 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b11;
    bus.abort     = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    for (int i = 0; i < FRAME; i++) ref_mem[i] = '0;

    // op, rand_data, gap_every, abort_at, stall, hold_nop, exp_done
    vecs[0]  = '{2'b10, 1'b0,  0, -1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{2'b00, 1'b0,  0, -1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{2'b01, 1'b0,  3, -1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{2'b00, 1'b0,  0, -1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{2'b00, 1'b0,  0, -1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{2'b01, 1'b1,  0,  5, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{2'b00, 1'b0,  0, -1, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{2'b11, 1'b0,  0, -1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{2'b01, 1'b1, -1, -1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{2'b00, 1'b0,  0, -1, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{2'b00, 1'b0,  0, -1, 1'b1, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    check_output("reset_cmd_ready", bus.cmd_ready, 1);
    check_output("reset_busy", bus.busy, 0);
    check_output("reset_rd_valid", bus.rd_valid, 0);
    check_output("reset_rd_data", 32'(bus.rd_data), 32'd0);
    check_output("reset_done", bus.done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) apply_stimulus(vecs[i]);

    // abort in IDLE must not block a command presented in the same cycle
    bus.abort     = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b11;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.abort     = 1'b0;
    check_output("idle_abort_cmd_done", bus.done, 1);
    @(negedge clk);

    // asynchronous reset while a pixel is being presented
    send_cmd(2'b00);
    bus.rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_output("pre_reset_rd_valid", bus.rd_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_rst_rd_valid", bus.rd_valid, 0);
    check_output("async_rst_busy", bus.busy, 0);
    check_output("async_rst_cmd_ready", bus.cmd_ready, 1);
    check_output("async_rst_rd_data", 32'(bus.rd_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(vecs[0]);
    apply_stimulus(vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
